value_stack_buffer: RTL and testbench

- Parametrised operand store for the MxV datapath. Successor to the fixed 8-bit/72-entry shift register value store.
- Holds up to DEPTH words of WIDTH bits and returns them in FIFO or LIFO order, selected by MODE.
- Provides occupancy count, full/empty flags, sticky overflow/underflow error flags and a registered read-data/valid output.
- Sits between the operand loader and the multiply-accumulate lanes.

---
 rtl/value_stack_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_value_stack_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/value_stack_buffer.sv
// value_stack_buffer: operand store between the operand loader and the MAC lanes.
// Holds up to DEPTH words of WIDTH bits and returns them oldest-first (MODE=0,
// FIFO) or newest-first (MODE=1, LIFO). The read port is registered: an
// accepted pop shows up on out_data/out_valid one cycle later.
//
// Optional build macro VALUE_BUF_REPLAY_EN adds a 'replay' input. In FIFO mode
// pops then no longer free storage, and a replay pulse re-streams every word
// written since the last clear. LIFO mode ignores replay.
//
// Handshake: push and pop are single-cycle requests sampled on the rising
// edge. A push is taken when there is room, or when the buffer is full and a
// pop is taken on the same edge. A pop is taken only when the buffer holds at
// least one word. A rejected request changes no data and sets the matching
// sticky error flag. out_valid is high for exactly one cycle per taken pop.
module value_stack_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 72,
  parameter int MODE  = 0,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
`ifdef VALUE_BUF_REPLAY_EN
  input  logic             replay,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam bit              IS_LIFO   = (MODE != 0);

  // Storage: no reset, contents are don't-care until written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Registered state.
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;
`ifdef VALUE_BUF_REPLAY_EN
  // Words written since the last clear; replay re-exposes all of them.
  logic [CNT_W-1:0] written_q,   written_d;
`endif

  // Per-cycle decisions.
  logic             full_w;
  logic             empty_w;
  logic             replay_hit;
  logic             pop_ok;
  logic             push_ok;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [PTR_W-1:0] mem_raddr;

  // Circular pointer advance, wrapping from the last entry back to entry 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Status flags and acceptance of the push/pop requests.
  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == DEPTH_CNT);
`ifdef VALUE_BUF_REPLAY_EN
    // In replay FIFO mode storage is only reclaimed by clear, so fullness
    // tracks how many words were ever written, not how many are unread.
    if (!IS_LIFO) begin
      full_w = (written_q == DEPTH_CNT);
    end
    replay_hit = replay && !IS_LIFO;
`else
    replay_hit = 1'b0;
`endif
    pop_ok  = pop && !empty_w && !clear && !replay_hit;
    push_ok = push && !clear && !replay_hit && (!full_w || pop_ok);
`ifdef VALUE_BUF_REPLAY_EN
    // A pop never frees a slot here, so a full buffer rejects every push.
    if (!IS_LIFO) begin
      push_ok = push && !clear && !replay_hit && !full_w;
    end
`endif
  end

  // Storage addressing: circular pointers for FIFO, top-of-stack for LIFO.
  always_comb begin
    if (IS_LIFO) begin
      // Top pointer equals count; a combined push+pop overwrites the old top.
      mem_raddr = PTR_W'(count_q - CNT_W'(1));
      mem_waddr = pop_ok ? PTR_W'(count_q - CNT_W'(1)) : PTR_W'(count_q);
    end else begin
      mem_raddr = rd_ptr_q;
      mem_waddr = wr_ptr_q;
    end
    mem_we = push_ok;
  end

  // Next-state for pointers, count, read port and sticky error flags.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
`ifdef VALUE_BUF_REPLAY_EN
    written_d   = written_q;
`endif

    if (clear) begin
      // Flush everything except the storage array and the last read word.
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
`ifdef VALUE_BUF_REPLAY_EN
      written_d   = '0;
`endif
    end else if (replay_hit) begin
`ifdef VALUE_BUF_REPLAY_EN
      // Rewind to the first word written after clear; push/pop are dropped.
      rd_ptr_d = '0;
      count_d  = written_q;
`endif
    end else begin
      if (push && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_d = 1'b1;
      end

      if (pop_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[mem_raddr];
      end

      if (!IS_LIFO) begin
        if (pop_ok) begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok) begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
      end

`ifdef VALUE_BUF_REPLAY_EN
      if (push_ok && (written_q != DEPTH_CNT)) begin
        written_d = written_q + CNT_W'(1);
      end
`endif

      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and read-port registers; reset discards all in-flight state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef VALUE_BUF_REPLAY_EN
      written_q   <= '0;
`endif
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef VALUE_BUF_REPLAY_EN
      written_q   <= written_d;
`endif
    end
  end

  // Storage write; blocked while reset is high so a reset never leaves a partial write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= in_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_value_stack_buffer.sv
// Directed bench for value_stack_buffer with WIDTH=8, DEPTH=4.
// One FIFO instance and one LIFO instance share clock, reset, clear and data.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
module tb_value_stack_buffer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          reset;
  logic          clear;
  logic [W-1:0]  in_data;
  logic          f_push, f_pop, l_push, l_pop;
  logic [W-1:0]  f_out, l_out;
  logic          f_valid, l_valid;
  logic [CW-1:0] f_count, l_count;
  logic          f_full, f_empty, f_ovf, f_udf;
  logic          l_full, l_empty, l_ovf, l_udf;
`ifdef VALUE_BUF_REPLAY_EN
  logic          replay;
`endif

  int            n_tests;
  int            n_fail;
  logic [W-1:0]  exp_q[$];

  value_stack_buffer #(.WIDTH(W), .DEPTH(D), .MODE(0)) u_fifo (
    .clk(clk), .reset(reset), .clear(clear),
`ifdef VALUE_BUF_REPLAY_EN
    .replay(replay),
`endif
    .in_data(in_data), .push(f_push), .pop(f_pop),
    .out_data(f_out), .out_valid(f_valid), .count(f_count),
    .full(f_full), .empty(f_empty), .overflow(f_ovf), .underflow(f_udf)
  );

  value_stack_buffer #(.WIDTH(W), .DEPTH(D), .MODE(1)) u_lifo (
    .clk(clk), .reset(reset), .clear(clear),
`ifdef VALUE_BUF_REPLAY_EN
    .replay(replay),
`endif
    .in_data(in_data), .push(l_push), .pop(l_pop),
    .out_data(l_out), .out_valid(l_valid), .count(l_count),
    .full(l_full), .empty(l_empty), .overflow(l_ovf), .underflow(l_udf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic f_op(input logic p, input logic q, input logic [W-1:0] d);
    f_push  = p;
    f_pop   = q;
    in_data = d;
    step();
    f_push  = 1'b0;
    f_pop   = 1'b0;
  endtask

  task automatic l_op(input logic p, input logic q, input logic [W-1:0] d);
    l_push  = p;
    l_pop   = q;
    in_data = d;
    step();
    l_push  = 1'b0;
    l_pop   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Scoreboard: pop (optionally with push) and compare with the next expected word
  task automatic f_xfer(input logic p, input logic [W-1:0] d, input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    f_op(p, 1'b1, d);
    check({tag, "_valid"}, 32'(f_valid), 32'd1);
    check({tag, "_data"},  32'(f_out),   32'(e));
  endtask

  task automatic l_xfer(input logic p, input logic [W-1:0] d, input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    l_op(p, 1'b1, d);
    check({tag, "_valid"}, 32'(l_valid), 32'd1);
    check({tag, "_data"},  32'(l_out),   32'(e));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    clear   = 1'b0;
    in_data = '0;
    f_push  = 1'b0;
    f_pop   = 1'b0;
    l_push  = 1'b0;
    l_pop   = 1'b0;
`ifdef VALUE_BUF_REPLAY_EN
    replay  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_count", 32'(f_count), 32'd0);
    check("rst_empty", 32'(f_empty), 32'd1);
    check("rst_full",  32'(f_full),  32'd0);
    check("rst_valid", 32'(f_valid), 32'd0);
    check("rst_data",  32'(f_out),   32'd0);
    check("rst_ovf",   32'(f_ovf),   32'd0);
    check("rst_udf",   32'(f_udf),   32'd0);
    check("rst_lcount", 32'(l_count), 32'd0);
    reset = 1'b0;
    step();

    // FIFO fill and drain
    f_op(1'b1, 1'b0, 8'h11);
    f_op(1'b1, 1'b0, 8'h22);
    f_op(1'b1, 1'b0, 8'h33);
    f_op(1'b1, 1'b0, 8'h44);
    check("t1_full",  32'(f_full),  32'd1);
    check("t1_count", 32'(f_count), 32'd4);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    repeat (4) f_xfer(1'b0, 8'h00, "t1_pop");
    check("t1_empty", 32'(f_empty), 32'd1);
    step();
    check("t1_idle_valid", 32'(f_valid), 32'd0);

    // LIFO order and underflow
    l_op(1'b1, 1'b0, 8'hA1);
    l_op(1'b1, 1'b0, 8'hA2);
    l_op(1'b1, 1'b0, 8'hA3);
    check("t2_count", 32'(l_count), 32'd3);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA1);
    repeat (3) l_xfer(1'b0, 8'h00, "t2_pop");
    l_op(1'b0, 1'b1, 8'h00);
    check("t2_udf",   32'(l_udf),   32'd1);
    check("t2_valid", 32'(l_valid), 32'd0);
    check("t2_data",  32'(l_out),   32'hA1);
    check("t2_count", 32'(l_count), 32'd0);

    // LIFO combined push+pop replaces the top
    l_op(1'b1, 1'b0, 8'hC1);
    l_op(1'b1, 1'b0, 8'hC2);
    exp_q.push_back(8'hC2);
    l_xfer(1'b1, 8'hB0, "t2b_swap");
    check("t2b_count", 32'(l_count), 32'd2);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hC1);
    repeat (2) l_xfer(1'b0, 8'h00, "t2b_pop");

    // Full FIFO: rejected push, then push+pop on full
    f_op(1'b1, 1'b0, 8'h01);
    f_op(1'b1, 1'b0, 8'h02);
    f_op(1'b1, 1'b0, 8'h03);
    f_op(1'b1, 1'b0, 8'h04);
    f_op(1'b1, 1'b0, 8'h05);
    check("t3_ovf",   32'(f_ovf),   32'd1);
    check("t3_count", 32'(f_count), 32'd4);
    exp_q.push_back(8'h01);
    f_xfer(1'b1, 8'h06, "t3_full_xfer");
    check("t3_count_keep", 32'(f_count), 32'd4);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h06);
    repeat (4) f_xfer(1'b0, 8'h00, "t3_pop");
    check("t3_empty", 32'(f_empty), 32'd1);

    // Clear flushes count and flags, keeps out_data
    do_clear();
    check("clr_ovf",   32'(f_ovf),   32'd0);
    check("clr_count", 32'(f_count), 32'd0);
    check("clr_data",  32'(f_out),   32'h06);
    check("clr_valid", 32'(f_valid), 32'd0);
    check("clr_ludf",  32'(l_udf),   32'd0);

    // Wrap-around with count <= 2
    f_op(1'b1, 1'b0, 8'h00);
    for (int i = 1; i < 10; i++) begin
      exp_q.push_back(8'(i - 1));
      f_xfer(1'b1, 8'(i), "t4_xfer");
      check("t4_count", 32'(f_count), 32'd1);
    end
    exp_q.push_back(8'h09);
    f_xfer(1'b0, 8'h00, "t4_last");
    check("t4_ovf", 32'(f_ovf), 32'd0);
    check("t4_udf", 32'(f_udf), 32'd0);

    // Push+pop on empty: only push is taken, no bypass
    f_op(1'b1, 1'b1, 8'h55);
    check("t5_udf",   32'(f_udf),   32'd1);
    check("t5_count", 32'(f_count), 32'd1);
    check("t5_valid", 32'(f_valid), 32'd0);
    check("t5_data",  32'(f_out),   32'h09);
    exp_q.push_back(8'h55);
    f_xfer(1'b0, 8'h00, "t5_pop");

    // Asynchronous reset mid-stream with a pop pending
    f_op(1'b1, 1'b0, 8'hC1);
    f_op(1'b1, 1'b0, 8'hC2);
    f_op(1'b1, 1'b0, 8'hC3);
    check("t6_count_pre", 32'(f_count), 32'd3);
    f_pop = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_async_count", 32'(f_count), 32'd0);
    step();
    f_pop = 1'b0;
    check("t6_count", 32'(f_count), 32'd0);
    check("t6_empty", 32'(f_empty), 32'd1);
    check("t6_valid", 32'(f_valid), 32'd0);
    check("t6_data",  32'(f_out),   32'd0);
    check("t6_udf",   32'(f_udf),   32'd0);
    reset = 1'b0;
    step();

    // Clear mid-stream with a pop pending
    f_op(1'b0, 1'b1, 8'h00);
    check("t7_udf_set", 32'(f_udf), 32'd1);
    f_op(1'b1, 1'b0, 8'h7A);
    f_op(1'b1, 1'b0, 8'h7B);
    f_op(1'b1, 1'b0, 8'h7C);
    exp_q.push_back(8'h7A);
    f_xfer(1'b0, 8'h00, "t7_pop");
    f_op(1'b1, 1'b0, 8'h7D);
    check("t7_count_pre", 32'(f_count), 32'd3);
    clear = 1'b1;
    f_pop = 1'b1;
    step();
    clear = 1'b0;
    f_pop = 1'b0;
    check("t7_count", 32'(f_count), 32'd0);
    check("t7_empty", 32'(f_empty), 32'd1);
    check("t7_valid", 32'(f_valid), 32'd0);
    check("t7_data",  32'(f_out),   32'h7A);
    check("t7_udf",   32'(f_udf),   32'd0);

`ifdef VALUE_BUF_REPLAY_EN
    // Replay re-streams the stored vector
    f_op(1'b1, 1'b0, 8'h10);
    f_op(1'b1, 1'b0, 8'h20);
    f_op(1'b1, 1'b0, 8'h30);
    check("t8_full", 32'(f_full), 32'd0);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    repeat (3) f_xfer(1'b0, 8'h00, "t8_pop");
    check("t8_count0", 32'(f_count), 32'd0);
    replay = 1'b1;
    step();
    replay = 1'b0;
    check("t8_count", 32'(f_count), 32'd3);
    check("t8_full2", 32'(f_full),  32'd0);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    repeat (3) f_xfer(1'b0, 8'h00, "t8_replay_pop");
    check("t8_full3", 32'(f_full), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
